// File: rtl/programmable_register_file.sv
// General-purpose register file: two combinational read ports, one synchronous write port.
// No write-through bypass; a write becomes visible on the read ports right after its edge.
module programmable_register_file #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned NUM_REGS   = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] input_reg_readA_address,
   input  logic [ADDR_WIDTH-1:0] input_reg_readB_address,
   input  logic                  input_reg_write,
   input  logic [DATA_WIDTH-1:0] input_reg_write_value,
   input  logic [ADDR_WIDTH-1:0] input_reg_write_address,
   output logic [DATA_WIDTH-1:0] output_reg_A,
   output logic [DATA_WIDTH-1:0] output_reg_B
);

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (input_reg_write) begin
         r_regs[input_reg_write_address] <= input_reg_write_value;
      end
   end

   always_comb begin
      output_reg_A = r_regs[input_reg_readA_address];
      output_reg_B = r_regs[input_reg_readB_address];
   end

endmodule

// File: tb/tb_programmable_register_file.sv
// Directed self-checking bench for programmable_register_file.
module tb_programmable_register_file;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 3;
   localparam int unsigned NR = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic [AW-1:0] rd_a;
   logic [AW-1:0] rd_b;
   logic          wr;
   logic [DW-1:0] wr_val;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] out_a;
   logic [DW-1:0] out_b;

   int vectors = 0;
   int errs    = 0;

   programmable_register_file #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REGS   (NR)
   ) dut (
      .CLK                     (CLK),
      .RST                     (RST),
      .input_reg_readA_address (rd_a),
      .input_reg_readB_address (rd_b),
      .input_reg_write         (wr),
      .input_reg_write_value   (wr_val),
      .input_reg_write_address (wr_addr),
      .output_reg_A            (out_a),
      .output_reg_B            (out_b)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset with a write attempt pending
      RST = 1'b1; rd_a = '0; rd_b = '0;
      wr = 1'b1; wr_val = 16'hDEAD; wr_addr = 3'd0;
      @(posedge CLK); #1;
      chk("reset_hold_A", out_a, 16'h0000);
      chk("reset_hold_B", out_b, 16'h0000);
      @(negedge CLK);
      RST = 1'b0; wr = 1'b0;
      #1;
      for (int i = 0; i < NR; i++) begin
         rd_a = 3'(i);
         rd_b = 3'(NR - 1 - i);
         #1;
         chk($sformatf("reset_clear_A%0d", i), out_a, 16'h0000);
         chk($sformatf("reset_clear_B%0d", NR - 1 - i), out_b, 16'h0000);
      end

      // write r1
      @(negedge CLK);
      wr = 1'b1; wr_addr = 3'd1; wr_val = 16'h1234;
      @(posedge CLK); #1;
      wr = 1'b0; rd_a = 3'd1;
      #1;
      chk("wr_r1_readA", out_a, 16'h1234);

      // write r2 while both ports read r1
      @(negedge CLK);
      rd_a = 3'd1; rd_b = 3'd1;
      wr = 1'b1; wr_addr = 3'd2; wr_val = 16'hABCD;
      @(posedge CLK); #1;
      wr = 1'b0;
      chk("other_reg_A", out_a, 16'h1234);
      chk("other_reg_B", out_b, 16'h1234);
      rd_a = 3'd2;
      #1;
      chk("read_r2_A", out_a, 16'hABCD);

      // write enable low for several edges
      @(negedge CLK);
      wr = 1'b0; wr_addr = 3'd1; wr_val = 16'hFFFF;
      repeat (3) @(posedge CLK);
      #1;
      rd_a = 3'd1;
      #1;
      chk("wr_disabled_r1", out_a, 16'h1234);

      // no bypass before the edge, visible right after it
      @(negedge CLK);
      rd_a = 3'd3;
      wr = 1'b1; wr_addr = 3'd3; wr_val = 16'h5A5A;
      #1;
      chk("no_bypass_pre", out_a, 16'h0000);
      @(posedge CLK); #1;
      chk("post_edge_r3", out_a, 16'h5A5A);
      wr = 1'b0;

      // boundary addresses, both ports on the same register
      @(negedge CLK);
      wr = 1'b1; wr_addr = 3'd0; wr_val = 16'h0F0F;
      @(negedge CLK);
      wr_addr = 3'd7; wr_val = 16'hF0F0;
      @(negedge CLK);
      wr = 1'b0;
      rd_a = 3'd0; rd_b = 3'd0;
      #1;
      chk("addr0_A", out_a, 16'h0F0F);
      chk("addr0_B", out_b, 16'h0F0F);
      rd_a = 3'd7; rd_b = 3'd7;
      #1;
      chk("addr7_A", out_a, 16'hF0F0);
      chk("addr7_B", out_b, 16'hF0F0);

      // only the value present at the edge is stored
      @(negedge CLK);
      wr = 1'b1; wr_addr = 3'd5; wr_val = 16'h1111;
      #2;
      wr_addr = 3'd4; wr_val = 16'h2222;
      @(posedge CLK); #1;
      wr = 1'b0;
      rd_a = 3'd4; rd_b = 3'd5;
      #1;
      chk("late_change_r4", out_a, 16'h2222);
      chk("late_change_r5", out_b, 16'h0000);

      // async reset between edges, write during reset discarded
      rd_a = 3'd1; rd_b = 3'd2;
      #1;
      chk("pre_rst_r1", out_a, 16'h1234);
      chk("pre_rst_r2", out_b, 16'hABCD);
      @(negedge CLK);
      #2;
      RST = 1'b1;
      wr = 1'b1; wr_addr = 3'd1; wr_val = 16'h7777;
      #1;
      chk("async_rst_A", out_a, 16'h0000);
      chk("async_rst_B", out_b, 16'h0000);
      @(posedge CLK); #1;
      chk("rst_wr_ignored", out_a, 16'h0000);
      @(negedge CLK);
      wr = 1'b0;
      RST = 1'b0;
      #1;
      for (int i = 0; i < NR; i++) begin
         rd_a = 3'(i);
         #1;
         chk($sformatf("post_rst_r%0d", i), out_a, 16'h0000);
      end

      // first write after reset release
      @(negedge CLK);
      wr = 1'b1; wr_addr = 3'd6; wr_val = 16'hC3C3;
      @(posedge CLK); #1;
      wr = 1'b0;
      rd_b = 3'd6;
      #1;
      chk("first_wr_after_rst", out_b, 16'hC3C3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
